ysyx_22040931_ifu_bpu: RTL

- Instruction-fetch stage with a direct-mapped branch target buffer (BTB) and 2-bit direction predictor.
- Holds the PC, drives the instruction-memory address, and latches the IF/ID pipeline register: pc, instruction and prediction (pre_jump, pre_branch).
- Sits directly upstream of the decode stage and consumes its resolution feedback: jump type, taken flag, target, misprediction flag and load stall.
- Redirects the PC and flushes the IF/ID register on a misprediction; trains the BTB on every resolved control-transfer instruction.

---
 rtl/ysyx_22040931_ifu_bpu.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_22040931_ifu_bpu.sv
// ---------------------------------------------------------------------------
// ysyx_22040931_ifu_bpu
//
// Instruction-fetch stage with a 16-entry direct-mapped branch target buffer
// and a 2-bit saturating direction counter per entry. Holds the PC, drives
// the instruction-memory address and owns the IF/ID pipeline register.
// Decode feeds back its resolution of each control transfer. This block uses
// that feedback to redirect and flush on a misprediction, to train the BTB,
// and to keep prediction statistics.
//
// Ports
//   clock, reset      system clock, asynchronous active-high reset
//   inst_addr         current fetch PC (combinational from the PC register)
//   inst_data         instruction at inst_addr, valid in the same cycle
//   stall             load-use stall from decode (freezes PC, IF/ID and BTB)
//   id_pc             PC of the instruction in decode
//   id_jumptype       00 none, 01 branch, 10 jal, 11 taken jalr
//   id_taken          resolved taken
//   id_target         resolved target
//   id_error_pre      decode found a misprediction
//   pc_o, instr_o     IF/ID pc and instruction
//   valid_o           IF/ID holds a real instruction
//   pre_jump          IF/ID predicted taken
//   pre_branch        IF/ID predicted target (0 when not predicted taken)
//   br_total          resolved control transfers
//   br_correct        correctly predicted control transfers
// ---------------------------------------------------------------------------
module ysyx_22040931_ifu_bpu #(
   parameter int              PC_W     = 64,
   parameter int              INST_W   = 32,
   parameter int              BTB_IDX  = 4,
   parameter logic [PC_W-1:0] RESET_PC = 64'h8000_0000
) (
   input  logic              clock,
   input  logic              reset,
   output logic [PC_W-1:0]   inst_addr,
   input  logic [INST_W-1:0] inst_data,
   input  logic              stall,
   input  logic [PC_W-1:0]   id_pc,
   input  logic [1:0]        id_jumptype,
   input  logic              id_taken,
   input  logic [PC_W-1:0]   id_target,
   input  logic              id_error_pre,
   output logic [PC_W-1:0]   pc_o,
   output logic [INST_W-1:0] instr_o,
   output logic              valid_o,
   output logic              pre_jump,
   output logic [PC_W-1:0]   pre_branch,
   output logic [31:0]       br_total,
   output logic [31:0]       br_correct
);

   localparam int                N_ENT   = 1 << BTB_IDX;
   localparam int                TAG_W   = PC_W - BTB_IDX - 2;
   localparam logic [1:0]        JT_NONE = 2'b00;
   localparam logic [1:0]        JT_BR   = 2'b01;
   localparam logic [1:0]        JT_JAL  = 2'b10;
   localparam logic [1:0]        JT_JALR = 2'b11;
   localparam logic [INST_W-1:0] NOP     = INST_W'(32'h0000_0013);

   // PC and IF/ID register
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [PC_W-1:0]   ifid_pc_q, ifid_pc_d;
   logic [INST_W-1:0] ifid_instr_q, ifid_instr_d;
   logic              ifid_valid_q, ifid_valid_d;
   logic              ifid_pj_q, ifid_pj_d;
   logic [PC_W-1:0]   ifid_pb_q, ifid_pb_d;
   logic [31:0]       total_q, total_d;
   logic [31:0]       correct_q, correct_d;

   // BTB storage
   logic [N_ENT-1:0]  btb_valid_q;
   logic [TAG_W-1:0]  btb_tag_q  [N_ENT];
   logic [1:0]        btb_type_q [N_ENT];
   logic [PC_W-1:0]   btb_tgt_q  [N_ENT];
   logic [1:0]        btb_ctr_q  [N_ENT];

   // ---------------- lookup (combinational on the fetch PC) ----------------
   logic [BTB_IDX-1:0] lk_idx;
   logic [TAG_W-1:0]   lk_tag;
   logic               lk_hit;
   logic               pred_taken;
   logic [PC_W-1:0]    pred_target;

   assign lk_idx      = pc_q[BTB_IDX+1:2];
   assign lk_tag      = pc_q[PC_W-1:BTB_IDX+2];
   assign lk_hit      = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
   // Only conditional branches consult the counter; jumps always predict taken.
   assign pred_taken  = lk_hit && ((btb_type_q[lk_idx] != JT_BR) || btb_ctr_q[lk_idx][1]);
   assign pred_target = btb_tgt_q[lk_idx];

   // ---------------- training from decode feedback ----------------
   logic [BTB_IDX-1:0] up_idx;
   logic [TAG_W-1:0]   up_tag;
   logic               up_en;
   logic               up_hit;
   logic [1:0]         up_ctr_cur;
   logic               wr_en;
   logic [1:0]         wr_ctr;
   logic [PC_W-1:0]    wr_tgt;

   assign up_idx     = id_pc[BTB_IDX+1:2];
   assign up_tag     = id_pc[PC_W-1:BTB_IDX+2];
   // A bubble in IF/ID or stale operands during a load stall must not train.
   assign up_en      = !stall && ifid_valid_q && (id_jumptype != JT_NONE);
   assign up_hit     = btb_valid_q[up_idx] && (btb_tag_q[up_idx] == up_tag);
   assign up_ctr_cur = btb_ctr_q[up_idx];

   // NOTE: every variable driven in an always_comb gets a default on entry so
   // no path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      wr_en  = 1'b0;
      wr_ctr = 2'b00;
      wr_tgt = id_target;
      if (up_en) begin
         case (id_jumptype)
            JT_BR: begin
               if (up_hit) begin
                  wr_en = 1'b1;
                  if (id_taken) begin
                     wr_ctr = (up_ctr_cur == 2'b11) ? 2'b11 : up_ctr_cur + 2'd1;
                  end else begin
                     wr_ctr = (up_ctr_cur == 2'b00) ? 2'b00 : up_ctr_cur - 2'd1;
                     // Not-taken outcome carries no useful target.
                     wr_tgt = btb_tgt_q[up_idx];
                  end
               end else if (id_taken) begin
                  // Allocate weakly taken; a not-taken miss is never allocated.
                  wr_en  = 1'b1;
                  wr_ctr = 2'b10;
               end
            end
            JT_JAL, JT_JALR: begin
               wr_en  = 1'b1;
               wr_ctr = 2'b11;
            end
            default: ;
         endcase
      end
   end

   // ---------------- next-state for PC, IF/ID and statistics ----------------
   always_comb begin
      pc_d         = pc_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_valid_d = ifid_valid_q;
      ifid_pj_d    = ifid_pj_q;
      ifid_pb_d    = ifid_pb_q;
      total_d      = total_q;
      correct_d    = correct_q;

      if (!stall) begin
         if (id_error_pre) begin
            pc_d         = id_taken ? id_target : id_pc + PC_W'(4);
            ifid_pc_d    = '0;
            ifid_instr_d = NOP;
            ifid_valid_d = 1'b0;
            ifid_pj_d    = 1'b0;
            ifid_pb_d    = '0;
         end else begin
            pc_d         = pred_taken ? pred_target : pc_q + PC_W'(4);
            ifid_pc_d    = pc_q;
            ifid_instr_d = inst_data;
            ifid_valid_d = 1'b1;
            ifid_pj_d    = pred_taken;
            ifid_pb_d    = pred_taken ? pred_target : '0;
         end
      end

      if (up_en) begin
         total_d = total_q + 32'd1;
         if (!id_error_pre) begin
            correct_d = correct_q + 32'd1;
         end
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every flop samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q         <= RESET_PC;
         ifid_pc_q    <= '0;
         ifid_instr_q <= NOP;
         ifid_valid_q <= 1'b0;
         ifid_pj_q    <= 1'b0;
         ifid_pb_q    <= '0;
         total_q      <= '0;
         correct_q    <= '0;
         btb_valid_q  <= '0;
      end else begin
         pc_q         <= pc_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_pj_q    <= ifid_pj_d;
         ifid_pb_q    <= ifid_pb_d;
         total_q      <= total_d;
         correct_q    <= correct_d;
         if (wr_en) begin
            btb_valid_q[up_idx] <= 1'b1;
         end
      end
   end

   // NOTE: the BTB payload has no reset; the cleared valid bits guarantee that
   // stale tag/target/counter contents are never used, and leaving the arrays
   // unreset lets them map onto plain storage.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         btb_tag_q[up_idx]  <= up_tag;
         btb_type_q[up_idx] <= id_jumptype;
         btb_tgt_q[up_idx]  <= wr_tgt;
         btb_ctr_q[up_idx]  <= wr_ctr;
      end
   end

   // ---------------- outputs ----------------
   assign inst_addr  = pc_q;
   assign pc_o       = ifid_pc_q;
   assign instr_o    = ifid_instr_q;
   assign valid_o    = ifid_valid_q;
   assign pre_jump   = ifid_pj_q;
   assign pre_branch = ifid_pb_q;
   assign br_total   = total_q;
   assign br_correct = correct_q;

endmodule
